// File: rtl/ip_tx_arbiter.sv
// rtl/ip_tx_arbiter.sv - round-robin owner of the shared IP transmit path
module ip_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int IPG_CYCLES = 12
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   req_length,
  input  logic [NUM_REQ-1:0]      req_is_icmp,
  input  logic [32*NUM_REQ-1:0]   req_dest_ip,
  input  logic [8*NUM_REQ-1:0]    req_data,
  output logic [NUM_REQ-1:0]      grant,
  output logic [NUM_REQ-1:0]      data_rd,
  output logic [NUM_REQ-1:0]      done,
  input  logic                    ip_active,
  output logic                    tx_enable,
  output logic [15:0]             length,
  output logic                    is_icmp,
  output logic [31:0]             destination_ip,
  output logic [7:0]              data_out
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam int GW   = (IPG_CYCLES > 1) ? $clog2(IPG_CYCLES + 1) : 1;
  localparam logic [IDXW:0]   NREQ     = (IDXW + 1)'(NUM_REQ);
  localparam logic [GW-1:0]   IPG_LOAD = GW'(IPG_CYCLES);
  localparam logic [IDXW-1:0] LAST_RST = IDXW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, SEND, DRAIN, GAP} state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   done_q, done_d;
  logic                 tx_enable_q, tx_enable_d;
  logic [15:0]          length_q, length_d;
  logic                 is_icmp_q, is_icmp_d;
  logic [31:0]          dest_q, dest_d;
  logic [IDXW-1:0]      last_q, last_d;
  logic [15:0]          bytes_left_q, bytes_left_d;
  logic [GW-1:0]        gap_q, gap_d;
  // a zero-length grant is held for one cycle, then retired with done
  logic                 zero_pend_q, zero_pend_d;

  logic                 win_found;
  logic [IDXW-1:0]      win_idx;
  logic [IDXW:0]        cand_sum;
  logic [IDXW:0]        cand_red;
  logic [15:0]          win_len;

  // round-robin search starting one past the last winner
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_sum  = '0;
    cand_red  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand_sum = {1'b0, last_q} + off[IDXW:0];
      cand_red = (cand_sum >= NREQ) ? (cand_sum - NREQ) : cand_sum;
      if (!win_found && req[cand_red[IDXW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand_red[IDXW-1:0];
      end
    end
  end

  assign win_len = req_length[{win_idx, 4'b0000} +: 16];

  // next-state and latched packet attributes
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    done_d       = '0;
    length_d     = length_q;
    is_icmp_d    = is_icmp_q;
    dest_d       = dest_q;
    last_d       = last_q;
    bytes_left_d = bytes_left_q;
    gap_d        = gap_q;
    zero_pend_d  = zero_pend_q;
    case (state_q)
      IDLE: begin
        if (zero_pend_q) begin
          done_d      = grant_q;
          grant_d     = '0;
          zero_pend_d = 1'b0;
        end else if (win_found) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          length_d         = win_len;
          is_icmp_d        = req_is_icmp[win_idx];
          dest_d           = req_dest_ip[{win_idx, 5'b00000} +: 32];
          bytes_left_d     = win_len;
          last_d           = win_idx;
          if (win_len != 16'd0) begin
            state_d = SEND;
          end else begin
            zero_pend_d = 1'b1;
          end
        end
      end
      SEND: begin
        bytes_left_d = bytes_left_q - 16'd1;
        if (bytes_left_q == 16'd1) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!ip_active) begin
          done_d  = grant_q;
          grant_d = '0;
          gap_d   = IPG_LOAD;
          state_d = (IPG_CYCLES == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gap_q > GW'(1)) begin
          gap_d = gap_q - GW'(1);
        end else begin
          gap_d   = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    tx_enable_d = (state_d == SEND);
  end

  // state register, asynchronous active-low reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      done_q       <= '0;
      tx_enable_q  <= 1'b0;
      length_q     <= '0;
      is_icmp_q    <= 1'b0;
      dest_q       <= '0;
      last_q       <= LAST_RST;
      bytes_left_q <= '0;
      gap_q        <= '0;
      zero_pend_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      tx_enable_q  <= tx_enable_d;
      length_q     <= length_d;
      is_icmp_q    <= is_icmp_d;
      dest_q       <= dest_d;
      last_q       <= last_d;
      bytes_left_q <= bytes_left_d;
      gap_q        <= gap_d;
      zero_pend_q  <= zero_pend_d;
    end
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign tx_enable      = tx_enable_q;
  assign length         = length_q;
  assign is_icmp        = is_icmp_q;
  assign destination_ip = dest_q;
  // last_q is the current owner while a packet is in flight
  assign data_rd        = (state_q == SEND) ? grant_q : '0;
  assign data_out       = (state_q == SEND) ? req_data[{last_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// tb/tb_ip_tx_arbiter.sv - directed bench for ip_tx_arbiter
module tb_ip_tx_arbiter;

  logic         clock;
  logic         reset;
  logic [3:0]   req;
  logic [63:0]  req_length;
  logic [3:0]   req_is_icmp;
  logic [127:0] req_dest_ip;
  logic [31:0]  req_data;
  logic [3:0]   grant, data_rd, done;
  logic         ip_active;
  logic         tx_enable;
  logic [15:0]  length;
  logic         is_icmp;
  logic [31:0]  destination_ip;
  logic [7:0]   data_out;

  logic [3:0]   reqb;
  logic [3:0]   gb, rdb, doneb;
  logic         ip_b, txb, icmpb;
  logic [15:0]  lenb;
  logic [31:0]  destb;
  logic [7:0]   dob;

  logic [15:0]  len_tab [4];
  logic [31:0]  dest_tab [4];
  logic [3:0]   icmp_tab;
  logic [7:0]   ptr [4];
  logic [4:0]   act_a = '0;
  logic [4:0]   act_b = '0;

  int checks = 0;
  int errors = 0;

  ip_tx_arbiter #(.NUM_REQ(4), .IPG_CYCLES(12)) dut (
    .clock(clock), .reset(reset), .req(req), .req_length(req_length),
    .req_is_icmp(req_is_icmp), .req_dest_ip(req_dest_ip), .req_data(req_data),
    .grant(grant), .data_rd(data_rd), .done(done), .ip_active(ip_active),
    .tx_enable(tx_enable), .length(length), .is_icmp(is_icmp),
    .destination_ip(destination_ip), .data_out(data_out)
  );

  ip_tx_arbiter #(.NUM_REQ(4), .IPG_CYCLES(0)) dut_b (
    .clock(clock), .reset(reset), .req(reqb), .req_length({4{16'd2}}),
    .req_is_icmp(4'b0000), .req_dest_ip(128'd0), .req_data(32'd0),
    .grant(gb), .data_rd(rdb), .done(doneb), .ip_active(ip_b),
    .tx_enable(txb), .length(lenb), .is_icmp(icmpb),
    .destination_ip(destb), .data_out(dob)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  for (genvar i = 0; i < 4; i++) begin : g_req
    assign req_length[16*i +: 16] = len_tab[i];
    assign req_dest_ip[32*i +: 32] = dest_tab[i];
    assign req_is_icmp[i] = icmp_tab[i];
    assign req_data[8*i +: 8] = (ptr[i] + 8'd1) * 8'h11 + 8'(i);
  end

  // requester byte pointers: advance after data_rd, rewind on done/reset
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) ptr[i] <= 8'd0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (done[i]) ptr[i] <= 8'd0;
        else if (data_rd[i]) ptr[i] <= ptr[i] + 8'd1;
      end
    end
  end

  // IP stage model: active while sending and for 22 cycles after
  always @(posedge clock) begin
    if (tx_enable) act_a <= 5'd22;
    else if (act_a != 5'd0) act_a <= act_a - 5'd1;
    if (txb) act_b <= 5'd22;
    else if (act_b != 5'd0) act_b <= act_b - 5'd1;
  end
  assign ip_active = (act_a != 5'd0);
  assign ip_b      = (act_b != 5'd0);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // wait for requester idx to be granted, check the whole packet to done
  task automatic serve(input int idx, input int drop_at);
    int cyc;
    int txc;
    logic [3:0] g;
    logic [7:0] eb;
    g = 4'b0001 << idx;
    cyc = 0;
    while (grant == 4'd0 && cyc < 200) begin
      tick();
      cyc++;
    end
    check("grant", grant, g);
    check("length", length, len_tab[idx]);
    check("dest", destination_ip, dest_tab[idx]);
    check("is_icmp", is_icmp, icmp_tab[idx]);
    txc = 0;
    cyc = 0;
    while (done == 4'd0 && cyc < 400) begin
      if (tx_enable) begin
        eb = 8'(txc + 1) * 8'h11 + 8'(idx);
        check("data_out", data_out, eb);
        check("data_rd", data_rd, g);
        check("length_hold", length, len_tab[idx]);
        txc++;
      end else begin
        check("data_out_idle", data_out, 8'h00);
      end
      if (txc == drop_at) req[idx] = 1'b0;
      tick();
      cyc++;
    end
    check("done", done, g);
    check("grant_at_done", grant, 4'd0);
    check("tx_cycles", txc, len_tab[idx]);
    check("grant_to_done", cyc, (len_tab[idx] == 16'd0) ? 1 : int'(len_tab[idx]) + 23);
    req[idx] = 1'b0;
  endtask

  initial begin
    int cnt;
    reset = 1'b0;
    req   = 4'd0;
    reqb  = 4'd0;
    len_tab[0] = 16'd4;  dest_tab[0] = 32'hC0A80002;
    len_tab[1] = 16'd3;  dest_tab[1] = 32'hC0A80003;
    len_tab[2] = 16'd6;  dest_tab[2] = 32'h0A000001;
    len_tab[3] = 16'd0;  dest_tab[3] = 32'hFFFFFFFF;
    icmp_tab   = 4'b1010;
    repeat (3) tick();
    check("rst_grant", grant, 4'd0);
    check("rst_tx_enable", tx_enable, 1'b0);
    check("rst_done", done, 4'd0);
    check("rst_data_rd", data_rd, 4'd0);
    check("rst_length", length, 16'd0);
    check("rst_dest", destination_ip, 32'd0);
    check("rst_is_icmp", is_icmp, 1'b0);
    check("rst_data_out", data_out, 8'd0);
    reset = 1'b1;
    tick();

    // single request, then spacing to the next grant across the gap
    req[0] = 1'b1;
    serve(0, -1);
    req[1] = 1'b1;
    cnt = 0;
    while (grant == 4'd0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("ipg_spacing", cnt, 13);
    serve(1, -1);

    // round robin after last grant to 1
    req[1] = 1'b1;
    req[2] = 1'b1;
    serve(2, -1);
    serve(1, -1);

    // request withdrawn mid-send
    req[2] = 1'b1;
    serve(2, 2);

    // all four after last grant to 2 (3 is zero-length)
    req = 4'b1111;
    serve(3, -1);
    serve(0, -1);
    serve(1, -1);
    serve(2, -1);

    // zero-length alone
    req[3] = 1'b1;
    serve(3, -1);

    // request pulse that no edge sees
    req[1] = 1'b1;
    #2;
    req[1] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("no_grant", grant, 4'd0);
    end

    // reset at byte 3 of 10
    len_tab[0] = 16'd10;
    req[0] = 1'b1;
    cnt = 0;
    while (grant == 4'd0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("rst_pkt_grant", grant, 4'b0001);
    tick();
    tick();
    check("byte3", data_out, 8'h33);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_tx", tx_enable, 1'b0);
    check("mid_rst_grant", grant, 4'd0);
    check("mid_rst_data_rd", data_rd, 4'd0);
    check("mid_rst_data_out", data_out, 8'd0);
    check("mid_rst_length", length, 16'd0);
    req[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mid_rst_done", done, 4'd0);
    end
    reset = 1'b1;
    tick();
    check("post_rst_done", done, 4'd0);
    check("post_rst_tx", tx_enable, 1'b0);
    req = 4'b0011;
    serve(0, -1);
    serve(1, -1);

    // gap disabled: back-to-back grants
    reqb = 4'b0011;
    cnt = 0;
    while (gb == 4'd0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("b_grant0", gb, 4'b0001);
    cnt = 0;
    while (doneb == 4'd0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("b_done0", doneb, 4'b0001);
    check("b_grant_at_done", gb, 4'd0);
    reqb[0] = 1'b0;
    tick();
    check("b_grant1_next", gb, 4'b0010);
    check("b_tx1_next", txb, 1'b1);
    cnt = 0;
    while (doneb == 4'd0 && cnt < 100) begin
      tick();
      cnt++;
    end
    check("b_done1", doneb, 4'b0010);
    reqb[1] = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
